regfile_access_ctrl: RTL

Initiator-side controller for the 32x32 register file. It accepts 32-bit RISC-V-format instructions and decodes rs1/rs2/rd. It issues the register-file read, waits out the registered read latency, and presents operands downstream on a valid/ready handshake. It also accepts writeback requests and serialises them against reads, because the register file honours only one of readEn/writeEn per cycle.

---
 rtl/regfile_access_ctrl.sv | 127 ++++++++++++
 1 files changed

// File: rtl/regfile_access_ctrl.sv
// Initiator-side controller for a 32x32 register file: decodes rs1/rs2/rd, issues the
// registered read, presents operands on a valid/ready handshake and serialises writebacks.
module regfile_access_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [31:0] instr,
  output logic        op_valid,
  input  logic        op_ready,
  output logic [31:0] op_rs1val,
  output logic [31:0] op_rs2val,
  output logic [4:0]  op_rd,
  output logic [31:0] op_instr,
  input  logic        wb_valid,
  output logic        wb_ready,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  output logic        rf_en,
  output logic        rf_readEn,
  output logic        rf_writeEn,
  output logic [4:0]  rf_rs1,
  output logic [4:0]  rf_rs2,
  output logic [4:0]  rf_rd,
  output logic [31:0] rf_dataIn,
  input  logic [31:0] rf_readOut1,
  input  logic [31:0] rf_readOut2
);

  typedef enum logic [1:0] {IDLE, RD_ISSUE, RD_WAIT, OUT} state_t;

  state_t      state_reg, state_next;
  logic [31:0] instr_reg;
  logic        op_valid_reg;
  logic [31:0] op_rs1val_reg, op_rs2val_reg, op_instr_reg;
  logic [4:0]  op_rd_reg;

  logic accept, issue, capture, retire, write_act;

  // Writebacks take priority in IDLE/RD_ISSUE; RD_WAIT refuses them so the
  // already-registered read data cannot go stale.
  always_comb begin
    state_next = state_reg;
    accept     = 1'b0;
    issue      = 1'b0;
    capture    = 1'b0;
    retire     = 1'b0;
    write_act  = 1'b0;
    if (en) begin
      case (state_reg)
        IDLE: begin
          if (wb_valid) begin
            write_act = 1'b1;
          end else if (instr_valid) begin
            accept     = 1'b1;
            state_next = RD_ISSUE;
          end
        end
        RD_ISSUE: begin
          if (wb_valid) begin
            write_act = 1'b1;
          end else begin
            issue      = 1'b1;
            state_next = RD_WAIT;
          end
        end
        RD_WAIT: begin
          capture    = 1'b1;
          state_next = OUT;
        end
        OUT: begin
          write_act = wb_valid;
          if (op_valid_reg && op_ready) begin
            retire     = 1'b1;
            state_next = IDLE;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg     <= IDLE;
      instr_reg     <= '0;
      op_valid_reg  <= 1'b0;
      op_rs1val_reg <= '0;
      op_rs2val_reg <= '0;
      op_rd_reg     <= '0;
      op_instr_reg  <= '0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        instr_reg <= instr;
      end
      if (capture) begin
        op_rs1val_reg <= (instr_reg[19:15] == 5'd0) ? 32'd0 : rf_readOut1;
        op_rs2val_reg <= (instr_reg[24:20] == 5'd0) ? 32'd0 : rf_readOut2;
        op_rd_reg     <= instr_reg[11:7];
        op_instr_reg  <= instr_reg;
        op_valid_reg  <= 1'b1;
      end else if (retire) begin
        op_valid_reg <= 1'b0;
      end
    end
  end

  assign instr_ready = accept;
  assign wb_ready    = write_act;
  assign rf_en       = en;
  assign rf_readEn   = issue;
  // x0 writes are acknowledged but never reach the register file.
  assign rf_writeEn  = write_act && (wb_rd != 5'd0);
  assign rf_rs1      = instr_reg[19:15];
  assign rf_rs2      = instr_reg[24:20];
  assign rf_rd       = write_act ? wb_rd   : instr_reg[11:7];
  assign rf_dataIn   = write_act ? wb_data : instr_reg;

  assign op_valid  = op_valid_reg;
  assign op_rs1val = op_rs1val_reg;
  assign op_rs2val = op_rs2val_reg;
  assign op_rd     = op_rd_reg;
  assign op_instr  = op_instr_reg;

endmodule
